// File: rtl/clint_trap_ctrl_pkg.sv
// rtl/clint_trap_ctrl_pkg.sv - shared types and constants for the core-local trap controller
package clint_trap_ctrl_pkg;

  // Trap sequencer states
  typedef enum logic [2:0] {
    S_IDLE,
    S_MEPC,
    S_MSTATUS,
    S_MCAUSE,
    S_ASSERT,
    S_MRET
  } state_e;

  // CSR addresses, zero-extended to the write-address port width
  localparam logic [31:0] CSR_MTVEC   = 32'h0000_0305;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;

  // System instruction encodings recognised in decode
  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  // Synchronous exception causes
  localparam logic [31:0] CAUSE_ECALL  = 32'd11;
  localparam logic [31:0] CAUSE_EBREAK = 32'd3;

  // mstatus bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;

  // mstatus on trap entry: stash MIE into MPIE, then disable interrupts
  function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  // mstatus on mret: restore MIE from MPIE, then set MPIE
  function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
    logic [31:0] r;
    r               = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/clint_trap_ctrl.sv
// rtl/clint_trap_ctrl.sv - trap/mret detector and CSR update sequencer driving the clint CSR port
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] ASYNC_CAUSE = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic [7:0]  int_flag_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  input  logic        csr_ex_we_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_e      state_q;
  logic [31:0] epc_q;
  logic [31:0] cause_q;
  logic        mret_q;

  logic idle;
  logic sync_det;
  logic mret_det;
  logic async_det;

  // Decode in idle only; sync exceptions beat mret, which beats interrupts
  always_comb begin
    idle      = (state_q == S_IDLE);
    sync_det  = idle && ((inst_i == INST_ECALL) || (inst_i == INST_EBREAK));
    mret_det  = idle && !sync_det && (inst_i == INST_MRET);
    async_det = idle && !sync_det && !mret_det &&
                (int_flag_i != 8'h00) && global_int_en_i && !hold_flag_ex_i;
  end

  // Sequencer state plus latched epc/cause; write states wait out ex CSR writes
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      epc_q   <= 32'h0;
      cause_q <= 32'h0;
      mret_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sync_det) begin
            epc_q   <= inst_addr_i;
            cause_q <= (inst_i == INST_ECALL) ? CAUSE_ECALL : CAUSE_EBREAK;
            mret_q  <= 1'b0;
            state_q <= S_MEPC;
          end else if (mret_det) begin
            mret_q  <= 1'b1;
            state_q <= S_MRET;
          end else if (async_det) begin
            epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
            cause_q <= ASYNC_CAUSE;
            mret_q  <= 1'b0;
            state_q <= S_MEPC;
          end
        end
        S_MEPC:    if (!csr_ex_we_i) state_q <= S_MSTATUS;
        S_MSTATUS: if (!csr_ex_we_i) state_q <= S_MCAUSE;
        S_MCAUSE:  if (!csr_ex_we_i) state_q <= S_ASSERT;
        S_MRET:    if (!csr_ex_we_i) state_q <= S_ASSERT;
        S_ASSERT:  state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

  // CSR port and redirect outputs decoded from the current state
  always_comb begin
    hold_flag_o  = !idle || sync_det || mret_det || async_det;
    we_o         = 1'b0;
    waddr_o      = 32'h0;
    data_o       = 32'h0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'h0;
    case (state_q)
      S_MEPC: begin
        we_o    = !csr_ex_we_i;
        waddr_o = CSR_MEPC;
        data_o  = epc_q;
      end
      S_MSTATUS: begin
        we_o    = !csr_ex_we_i;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_trap(csr_mstatus_i);
      end
      S_MCAUSE: begin
        we_o    = !csr_ex_we_i;
        waddr_o = CSR_MCAUSE;
        data_o  = cause_q;
      end
      S_MRET: begin
        we_o    = !csr_ex_we_i;
        waddr_o = CSR_MSTATUS;
        data_o  = mstatus_on_mret(csr_mstatus_i);
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = mret_q ? csr_mepc_i : csr_mtvec_i;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/clint_trap_ctrl.md
# clint_trap_ctrl

Core-local trap controller; the initiator side of the CSR register file's second ("clint") access port. It detects ecall/ebreak/mret in decode and pending external interrupts. It stalls the pipeline, sequences the mepc/mstatus/mcause updates through the CSR clint write port, then redirects fetch to mtvec (trap entry) or mepc (mret).

## Interface
Parameters:
- ASYNC_CAUSE, 32'h8000_0004, mcause value written for an external/timer interrupt.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset; one clock, synchronous, active-low.
- inst_i  in  32  instruction currently in decode.
- inst_addr_i  in  32  PC of inst_i.
- jump_flag_i  in  1  ex is redirecting this cycle.
- jump_addr_i  in  32  ex redirect target.
- hold_flag_ex_i  in  1  ex multi-cycle op busy (e.g. divider).
- int_flag_i  in  8  external interrupt lines, level.
- global_int_en_i  in  1  mstatus.MIE from CSR file.
- csr_mtvec_i, csr_mepc_i, csr_mstatus_i  in  32 each  live CSR values.
- csr_ex_we_i  in  1  ex is writing a CSR this cycle.
- hold_flag_o  out  1  stall request to pipeline control.
- we_o  out  1  CSR write enable (clint port).
- waddr_o  out  32  CSR write address, low 12 bits significant.
- data_o  out  32  CSR write data.
- int_assert_o  out  1  one-cycle fetch redirect strobe.
- int_addr_o  out  32  redirect target; valid only with int_assert_o.

## Operation
- Decode, evaluated only in S_IDLE: ECALL = 32'h0000_0073 (cause 11); EBREAK = 32'h0010_0073 (cause 3); MRET = 32'h3020_0073.
- Async trap condition: int_flag_i != 0, global_int_en_i = 1 and hold_flag_ex_i = 0.
- Priority: sync (ecall/ebreak) > mret > async.
- An async request that is not taken is not latched. It is re-evaluated every idle cycle, because the lines are level.
- Latched on trap detect:
  - cause.
  - epc: inst_addr_i for sync. For async, jump_addr_i if jump_flag_i, else inst_addr_i.
- FSM states: S_IDLE, S_MEPC, S_MSTATUS, S_MCAUSE, S_ASSERT, S_MRET.
- Trap entry: IDLE → S_MEPC → S_MSTATUS → S_MCAUSE → S_ASSERT → IDLE.
  - S_MEPC writes epc to 0x341.
  - S_MSTATUS writes to 0x300 the value csr_mstatus_i with bit7 (MPIE) = bit3 (MIE) and bit3 = 0.
  - S_MCAUSE writes cause to 0x342.
  - S_ASSERT drives int_assert_o = 1 and int_addr_o = csr_mtvec_i.
- Mret: IDLE → S_MRET → S_ASSERT → IDLE.
  - S_MRET writes to 0x300 the value csr_mstatus_i with bit3 = bit7 and bit7 = 1.
  - S_ASSERT then drives int_addr_o = csr_mepc_i.
- Write arbitration: the CSR file gives ex writes priority over clint writes. Each write state therefore asserts we_o only when csr_ex_we_i = 0. Otherwise it holds state with we_o = 0 and retries next cycle, so no write is lost.
- hold_flag_o = (state != S_IDLE) | (a trap or mret is detected in S_IDLE). It is combinational, so the pipeline freezes in the detect cycle.
- In S_IDLE and S_ASSERT: we_o = 0, waddr_o = 0, data_o = 0. Outside S_ASSERT: int_assert_o = 0, int_addr_o = 0.

## Timing
- Reset (rst = 0 at a clk edge): state = S_IDLE, latched epc/cause = 0, all outputs 0 from the next cycle on.
- Reset mid-sequence aborts with no int_assert_o pulse. CSR writes already performed stand.
- Trap detected in cycle T with no ex CSR writes:
  - hold_flag_o high from T through T+4.
  - we_o at T+1 (mepc), T+2 (mstatus), T+3 (mcause).
  - int_assert_o at T+4.
  - S_IDLE at T+5 with hold low, unless a new trap is detected.
- Mret in cycle T: mstatus write at T+1, int_assert_o at T+2, IDLE at T+3.
- Each csr_ex_we_i-blocked cycle adds exactly one cycle of latency.
- An async interrupt coincident with ecall: ecall taken. The async request is then masked by MIE = 0 until mret.
- inst_i/int_flag_i changes while not in S_IDLE are ignored.

## Structure
- Shared package:
  - state enum.
  - CSR address constants (MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MSTATUS 0x300).
  - ECALL/EBREAK/MRET encodings.
  - cause constants (11, 3).
  - mstatus bit indices (MIE = 3, MPIE = 7).
- Single module: one FSM register plus epc/cause holding registers; no sub-module is warranted.

## Test plan
- ecall at inst_addr_i = 0x100, mstatus = 0x08, mtvec = 0x200:
  - writes in order: 0x341 ← 0x100, 0x300 ← 0x80, 0x342 ← 11.
  - int_assert_o at T+4 with int_addr_o = 0x200.
  - hold_flag_o high for exactly 5 cycles.
- int_flag_i = 8'h01, MIE = 1, jump_flag_i = 1, jump_addr_i = 0x44:
  - mepc ← 0x44, mcause ← 32'h8000_0004.
  - Repeat with MIE = 0 or hold_flag_ex_i = 1: no trap.
- mret with mstatus = 0x80, mepc = 0x104: 0x300 ← 0x88; int_assert_o at T+2 with int_addr_o = 0x104.
- csr_ex_we_i high for 2 cycles during S_MEPC: we_o withheld for those 2 cycles; mepc written at T+3; int_assert_o at T+6.
- rst pulsed low in S_MSTATUS: no int_assert_o, all outputs 0, state IDLE. A subsequent ebreak writes mcause ← 3.
